ramb4_nibble_dibit_reader: RTL and testbench

Read-side streaming engine for the 4-bit port of a dual-width block RAM. On command, it fetches a run of 4-bit words over a synchronous RAM read port and emits them as a 2-bit symbol stream under a valid/ready handshake. This is the reverse of the 2-bit-write / 4-bit-read path: it unpacks packed nibbles back into dibits. It sits between the RAM's B-side read port and a 2-bit downstream consumer.

---
 rtl/ramb4_nibble_dibit_reader.sv | 160 ++++++++++++++++
 tb/tb_ramb4_nibble_dibit_reader.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramb4_nibble_dibit_reader.sv
// Streams a run of 4-bit RAM words out as 2-bit symbols under valid/ready.
// Optional macro DIBIT_MSB_FIRST_EN: emit nibble bits [3:2] before [1:0].
module ramb4_nibble_dibit_reader (
  input  logic        CLKA,
  input  logic        RSTB,
  input  logic        START,
  input  logic [9:0]  BASE,
  input  logic [10:0] LEN,
  output logic        RD_EN,
  output logic [9:0]  RD_ADDR,
  input  logic [3:0]  RD_DO,
  output logic [1:0]  DO,
  output logic        DO_VALID,
  input  logic        DO_READY,
  output logic        DO_LAST,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            rd_en_q, rd_en_d;
  logic [9:0]      addr_q, addr_d;
  logic            pend_q;
  logic [10:0]     issue_rem_q, issue_rem_d;
  logic [10:0]     out_rem_q, out_rem_d;
  logic [1:0][3:0] fifo_q;
  logic [1:0]      cnt_q, cnt_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            phase_q, phase_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [3:0]      head_s;
  logic            valid_s;
  logic            xfer_s;
  logic            pop_s;
  logic            final_s;
  logic [2:0]      occ_s;
  logic            credit_s;
  logic [1:0]      do_s;

  // Next-state, read issue and symbol selection.
  always_comb begin
    head_s   = fifo_q[rd_ptr_q];
    valid_s  = (cnt_q != 2'd0);
    xfer_s   = valid_s && DO_READY;
    pop_s    = xfer_s && phase_q;
    final_s  = pop_s && (out_rem_q == 11'd1);
    // A nibble popping this edge frees its slot for a read issued on the same edge.
    occ_s    = {1'b0, cnt_q} + {2'b00, rd_en_q} + {2'b00, pend_q} - {2'b00, pop_s};
    credit_s = (occ_s < 3'd2);

    state_d     = state_q;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    issue_rem_d = issue_rem_q;
    out_rem_d   = out_rem_q - {10'd0, pop_s};
    cnt_d       = cnt_q + {1'b0, pend_q} - {1'b0, pop_s};
    wr_ptr_d    = wr_ptr_q ^ pend_q;
    rd_ptr_d    = rd_ptr_q ^ pop_s;
    phase_d     = xfer_s ? ~phase_q : phase_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START && (LEN == 11'd0)) begin
          done_d = 1'b1;
        end else if (START) begin
          rd_en_d     = 1'b1;
          addr_d      = BASE;
          issue_rem_d = LEN - 11'd1;
          out_rem_d   = LEN;
          state_d     = (LEN == 11'd1) ? ST_DRAIN : ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (credit_s && (issue_rem_q != 11'd0)) begin
          rd_en_d     = 1'b1;
          addr_d      = addr_q + 10'd1;
          issue_rem_d = issue_rem_q - 11'd1;
          state_d     = (issue_rem_q == 11'd1) ? ST_DRAIN : ST_FETCH;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (final_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);

`ifdef DIBIT_MSB_FIRST_EN
    do_s = phase_q ? head_s[1:0] : head_s[3:2];
`else
    do_s = phase_q ? head_s[3:2] : head_s[1:0];
`endif
  end

  // State, pipeline and nibble buffer registers.
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      state_q     <= ST_IDLE;
      rd_en_q     <= 1'b0;
      addr_q      <= 10'd0;
      pend_q      <= 1'b0;
      issue_rem_q <= 11'd0;
      out_rem_q   <= 11'd0;
      fifo_q      <= 8'h00;
      cnt_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      phase_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      pend_q      <= rd_en_q;
      issue_rem_q <= issue_rem_d;
      out_rem_q   <= out_rem_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      if (pend_q) begin
        fifo_q[wr_ptr_q] <= RD_DO;
      end
    end
  end

  assign RD_EN    = rd_en_q;
  assign RD_ADDR  = addr_q;
  assign DO       = do_s;
  assign DO_VALID = valid_s;
  assign DO_LAST  = valid_s && phase_q && (out_rem_q == 11'd1);
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_ramb4_nibble_dibit_reader.sv
// Scoreboard bench for ramb4_nibble_dibit_reader with a behavioural RAM model.
module tb_ramb4_nibble_dibit_reader;

  logic        CLKA;
  logic        RSTB;
  logic        START;
  logic [9:0]  BASE;
  logic [10:0] LEN;
  logic        RD_EN;
  logic [9:0]  RD_ADDR;
  logic [3:0]  RD_DO;
  logic [1:0]  DO;
  logic        DO_VALID;
  logic        DO_READY;
  logic        DO_LAST;
  logic        BUSY;
  logic        DONE;

  logic [3:0]  mem [1024];

  int          n_vec;
  int          n_err;
  int          cyc;
  int          rdy_mode;
  int          outstanding;
  int          xfer_cnt;
  int          done_cnt;
  int          rd_cnt;
  bit          half;
  bit          stall_prev;
  bit          last_pend;
  bit          cur_xfer;
  logic [1:0]  stall_do;
  logic        stall_last;
  logic [2:0]  exp_q [$];

  ramb4_nibble_dibit_reader dut (
    .CLKA    (CLKA),
    .RSTB    (RSTB),
    .START   (START),
    .BASE    (BASE),
    .LEN     (LEN),
    .RD_EN   (RD_EN),
    .RD_ADDR (RD_ADDR),
    .RD_DO   (RD_DO),
    .DO      (DO),
    .DO_VALID(DO_VALID),
    .DO_READY(DO_READY),
    .DO_LAST (DO_LAST),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  initial begin
    CLKA = 1'b0;
    forever #5 CLKA = ~CLKA;
  end

  // Synchronous-read RAM: data for an address sampled at one edge appears after it.
  always @(posedge CLKA) begin
    if (RD_EN) RD_DO <= mem[RD_ADDR];
  end

  // One cycle: drive DO_READY for the coming edge, then observe outputs and check.
  task automatic tick();
    logic [2:0] e;
    @(negedge CLKA);
    cyc++;
    case (rdy_mode)
      0:       DO_READY = 1'b1;
      1:       DO_READY = 1'($urandom_range(0, 1));
      default: DO_READY = 1'b0;
    endcase
    cur_xfer = 1'b0;
    if (RSTB) begin
      exp_q.delete();
      outstanding = 0;
      half        = 1'b0;
      stall_prev  = 1'b0;
      last_pend   = 1'b0;
    end else begin
      if (last_pend) begin
        n_vec++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
          n_err++;
          $display("FAIL done_after_last: DONE=%b BUSY=%b, expected DONE=1 BUSY=0", DONE, BUSY);
        end
      end
      if (stall_prev) begin
        n_vec++;
        if (DO_VALID !== 1'b1 || DO !== stall_do || DO_LAST !== stall_last) begin
          n_err++;
          $display("FAIL stall_hold: valid=%b do=%b last=%b, expected valid=1 do=%b last=%b",
                   DO_VALID, DO, DO_LAST, stall_do, stall_last);
        end
      end
      if (DONE === 1'b1) done_cnt++;
      if (RD_EN === 1'b1) begin
        rd_cnt++;
        outstanding++;
        n_vec++;
        if (outstanding > 2) begin
          n_err++;
          $display("FAIL credit: %0d reads outstanding or buffered, expected at most 2", outstanding);
        end
      end
      if (DO_VALID === 1'b1 && DO_READY === 1'b1) begin
        cur_xfer = 1'b1;
        xfer_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_dibit: got last=%b do=%b, expected no transfer", DO_LAST, DO);
        end else begin
          e = exp_q.pop_front();
          if ({DO_LAST, DO} !== e) begin
            n_err++;
            $display("FAIL dibit: got last=%b do=%b, expected last=%b do=%b", DO_LAST, DO, e[2], e[1:0]);
          end
        end
        if (half) outstanding--;
        half = ~half;
      end
      stall_prev = (DO_VALID === 1'b1) && (DO_READY === 1'b0);
      stall_do   = DO;
      stall_last = DO_LAST;
      last_pend  = (DO_VALID === 1'b1) && (DO_READY === 1'b1) && (DO_LAST === 1'b1);
    end
  endtask

  task automatic push_exp(input logic [9:0] base, input logic [10:0] len);
    logic [3:0] nib;
    for (int n = 0; n < int'(len); n++) begin
      nib = mem[base + 10'(n)];
`ifdef DIBIT_MSB_FIRST_EN
      exp_q.push_back({1'b0, nib[3:2]});
      exp_q.push_back({(n == int'(len) - 1), nib[1:0]});
`else
      exp_q.push_back({1'b0, nib[1:0]});
      exp_q.push_back({(n == int'(len) - 1), nib[3:2]});
`endif
    end
  endtask

  // Strobe START for one edge; returns in the cycle after the accepting edge.
  task automatic issue_cmd(input logic [9:0] base, input logic [10:0] len, input bit expect_run);
    START = 1'b1;
    BASE  = base;
    LEN   = len;
    if (expect_run) push_exp(base, len);
    tick();
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (DONE === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL %s_timeout: no DONE within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    RSTB = 1'b1;
    START = 1'b1;
    BASE = 10'h155;
    LEN = 11'd2;
    tick();
    tick();
    START = 1'b0;
    tick();
    n_vec++;
    if ({RD_EN, RD_ADDR, DO, DO_VALID, DO_LAST, BUSY, DONE} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_values: got %h, expected 0", {RD_EN, RD_ADDR, DO, DO_VALID, DO_LAST, BUSY, DONE});
    end
    RSTB = 1'b0;
    tick();
    n_vec++;
    if (BUSY !== 1'b0 || RD_EN !== 1'b0) begin
      n_err++;
      $display("FAIL reset_priority: BUSY=%b RD_EN=%b, expected 0 0", BUSY, RD_EN);
    end
  endtask

  task automatic test_basic();
    logic [9:0] addrs [$];
    logic [2:0] seq [$];
    logic [7:0] exp8;
    int first_k, last_k, done_k;
`ifdef DIBIT_MSB_FIRST_EN
    exp8 = 8'b10_01_01_10;
`else
    exp8 = 8'b01_10_10_01;
`endif
    mem[10'h005] = 4'h9;
    mem[10'h006] = 4'h6;
    rdy_mode = 0;
    first_k = -1;
    last_k = -1;
    done_k = -1;
    issue_cmd(10'h005, 11'd2, 1'b1);
    for (int k = 0; k < 30; k++) begin
      if (k > 0) tick();
      if (RD_EN === 1'b1) addrs.push_back(RD_ADDR);
      if (cur_xfer) begin
        if (first_k < 0) first_k = k;
        seq.push_back({DO_LAST, DO});
        if (DO_LAST === 1'b1) last_k = k;
      end
      if (DONE === 1'b1) begin
        done_k = k;
        break;
      end
    end
    n_vec++;
    if (seq.size() != 4) begin
      n_err++;
      $display("FAIL basic_count: got %0d dibits, expected 4", seq.size());
    end
    for (int i = 0; i < 4 && i < seq.size(); i++) begin
      n_vec++;
      if (seq[i] !== {(i == 3), exp8[(3 - i) * 2 +: 2]}) begin
        n_err++;
        $display("FAIL basic_dibit%0d: got last=%b do=%b, expected last=%b do=%b",
                 i, seq[i][2], seq[i][1:0], (i == 3), exp8[(3 - i) * 2 +: 2]);
      end
    end
    n_vec++;
    if (addrs.size() != 2 || addrs[0] !== 10'h005 || addrs[1] !== 10'h006) begin
      n_err++;
      $display("FAIL basic_addr: got %0d reads, expected 0x005,0x006", addrs.size());
    end
    n_vec++;
    if (first_k != 2) begin
      n_err++;
      $display("FAIL basic_latency: first dibit at cycle %0d, expected 2", first_k);
    end
    n_vec++;
    if (done_k < 0 || done_k != last_k + 1) begin
      n_err++;
      $display("FAIL basic_done: DONE at cycle %0d, expected %0d", done_k, last_k + 1);
    end
  endtask

  task automatic test_back_to_back();
    issue_cmd(10'h006, 11'd1, 1'b1);
    n_vec++;
    if (BUSY !== 1'b1 || RD_EN !== 1'b1 || RD_ADDR !== 10'h006) begin
      n_err++;
      $display("FAIL b2b_accept: BUSY=%b RD_EN=%b RD_ADDR=%h, expected 1 1 006", BUSY, RD_EN, RD_ADDR);
    end
    wait_done(20, "b2b");
  endtask

  task automatic test_backpressure();
    int x0, r0;
    x0 = xfer_cnt;
    r0 = rd_cnt;
    rdy_mode = 1;
    issue_cmd(10'h120, 11'd4, 1'b1);
    repeat (4) tick();
    rdy_mode = 2;
    repeat (10) tick();
    n_vec++;
    if (DO_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL bp_valid_held: DO_VALID=%b during stall, expected 1", DO_VALID);
    end
    rdy_mode = 1;
    wait_done(200, "bp");
    rdy_mode = 0;
    n_vec++;
    if (xfer_cnt - x0 != 8 || rd_cnt - r0 != 4) begin
      n_err++;
      $display("FAIL bp_counts: got %0d dibits %0d reads, expected 8 4", xfer_cnt - x0, rd_cnt - r0);
    end
  endtask

  task automatic test_wrap();
    logic [9:0] addrs [$];
    issue_cmd(10'h3FF, 11'd2, 1'b1);
    for (int k = 0; k < 30; k++) begin
      if (k > 0) tick();
      if (RD_EN === 1'b1) addrs.push_back(RD_ADDR);
      if (DONE === 1'b1) break;
    end
    n_vec++;
    if (addrs.size() != 2 || addrs[0] !== 10'h3FF || addrs[1] !== 10'h000) begin
      n_err++;
      $display("FAIL wrap_addr: got %0d reads, expected 0x3FF,0x000", addrs.size());
    end
  endtask

  task automatic test_len_max();
    int x0, r0, d0, first_c;
    x0 = xfer_cnt;
    r0 = rd_cnt;
    d0 = done_cnt;
    first_c = -1;
    rdy_mode = 0;
    issue_cmd(10'h200, 11'd1024, 1'b1);
    for (int k = 0; k < 2200; k++) begin
      tick();
      if (cur_xfer && first_c < 0) first_c = cyc;
      if (DONE === 1'b1) break;
    end
    n_vec++;
    if (xfer_cnt - x0 != 2048 || rd_cnt - r0 != 1024 || done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL lenmax_counts: got %0d dibits %0d reads %0d done, expected 2048 1024 1",
               xfer_cnt - x0, rd_cnt - r0, done_cnt - d0);
    end
    n_vec++;
    if (cyc - 1 - first_c + 1 != 2048) begin
      n_err++;
      $display("FAIL lenmax_throughput: stream spanned %0d cycles, expected 2048", cyc - first_c);
    end
  endtask

  task automatic test_len_zero();
    int r0;
    r0 = rd_cnt;
    issue_cmd(10'h010, 11'd0, 1'b0);
    n_vec++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || RD_EN !== 1'b0) begin
      n_err++;
      $display("FAIL len0_done: DONE=%b BUSY=%b RD_EN=%b, expected 1 0 0", DONE, BUSY, RD_EN);
    end
    repeat (3) tick();
    n_vec++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || rd_cnt != r0) begin
      n_err++;
      $display("FAIL len0_quiet: DONE=%b BUSY=%b reads=%0d, expected 0 0 0", DONE, BUSY, rd_cnt - r0);
    end
  endtask

  task automatic test_reset_mid();
    int x0, d0;
    x0 = xfer_cnt;
    rdy_mode = 0;
    issue_cmd(10'h040, 11'd8, 1'b1);
    for (int k = 0; k < 30; k++) begin
      if (xfer_cnt - x0 >= 3) break;
      tick();
    end
    rdy_mode = 2;
    tick();
    RSTB = 1'b1;
    tick();
    n_vec++;
    if ({RD_EN, RD_ADDR, DO, DO_VALID, DO_LAST, BUSY, DONE} !== 17'd0) begin
      n_err++;
      $display("FAIL abort_values: got %h, expected 0", {RD_EN, RD_ADDR, DO, DO_VALID, DO_LAST, BUSY, DONE});
    end
    RSTB = 1'b0;
    rdy_mode = 0;
    d0 = done_cnt;
    repeat (10) tick();
    n_vec++;
    if (done_cnt != d0 || BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_done: %0d DONE pulses BUSY=%b, expected 0 0", done_cnt - d0, BUSY);
    end
    x0 = xfer_cnt;
    issue_cmd(10'h050, 11'd1, 1'b1);
    wait_done(20, "after_abort");
    tick();
    n_vec++;
    if (xfer_cnt - x0 != 2) begin
      n_err++;
      $display("FAIL after_abort_count: got %0d dibits, expected 2", xfer_cnt - x0);
    end
  endtask

  task automatic test_start_busy();
    int x0, d0, r0;
    x0 = xfer_cnt;
    d0 = done_cnt;
    r0 = rd_cnt;
    rdy_mode = 0;
    issue_cmd(10'h080, 11'd3, 1'b1);
    tick();
    issue_cmd(10'h300, 11'd5, 1'b0);
    wait_done(40, "busy");
    repeat (5) tick();
    n_vec++;
    if (xfer_cnt - x0 != 6 || done_cnt - d0 != 1 || rd_cnt - r0 != 3) begin
      n_err++;
      $display("FAIL start_busy: got %0d dibits %0d done %0d reads, expected 6 1 3",
               xfer_cnt - x0, done_cnt - d0, rd_cnt - r0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    rdy_mode = 0;
    outstanding = 0;
    xfer_cnt = 0;
    done_cnt = 0;
    rd_cnt = 0;
    half = 1'b0;
    stall_prev = 1'b0;
    last_pend = 1'b0;
    cur_xfer = 1'b0;
    RSTB = 1'b1;
    START = 1'b0;
    BASE = 10'd0;
    LEN = 11'd0;
    DO_READY = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom);

    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_len_max();
    test_len_zero();
    test_reset_mid();
    test_start_busy();

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d expected dibits never produced, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
